// File: rtl/instr_fetch_buffer.sv
// Instruction fetch stage: sequential prefetch over a req/ack memory port into a small {pc, instr} FIFO.
// Optional misaligned-redirect trap is built when IFB_MISALIGN_CHECK_EN is defined.
module instr_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        fetch_fault
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

`ifdef IFB_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP, S_FAULT} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_e;
`endif

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic          mem_req_q, mem_req_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d, pop_w, push_w;
  logic          instr_valid_q, instr_valid_d;
  logic [31:0]   instr_q, instr_d, pc_q, pc_d;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pcs_q  [DEPTH];
  logic          pop, push;
  logic [31:0]   rpc;

`ifdef IFB_MISALIGN_CHECK_EN
  logic fault_q, fault_d;
  assign rpc         = redirect_pc;
  assign fetch_fault = fault_q;
`else
  assign rpc         = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_fault = 1'b0;
`endif

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instruction = instr_q;
  assign pc          = pc_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    // A redirect flushes the FIFO, so a pop in that cycle is dropped.
    pop        = instr_valid_q & instr_ready & ~redirect;
    pop_w      = (PW+1)'(pop);
    if (redirect) fetch_pc_d = rpc;

    case (state_q)
      S_IDLE: begin
        if (redirect || ((count_q - pop_w) < DEPTH_C)) state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_ack) begin
          if (!redirect) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = ((count_q + (PW+1)'(1) - pop_w) < DEPTH_C) ? S_REQ : S_IDLE;
          end
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (mem_ack) state_d = S_REQ;
      end
`ifdef IFB_MISALIGN_CHECK_EN
      S_FAULT: begin
        if (redirect) state_d = S_REQ;
      end
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef IFB_MISALIGN_CHECK_EN
    // Any would-be request to a misaligned target parks in FAULT instead.
    if ((state_d == S_REQ) && (fetch_pc_d[1:0] != 2'b00)) state_d = S_FAULT;
    fault_d = redirect ? (redirect_pc[1:0] != 2'b00) : fault_q;
`endif

    push_w = (PW+1)'(push);
    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = count_q + push_w - pop_w;
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
    end

    mem_req_d     = (state_d == S_REQ) || (state_d == S_DROP);
    mem_addr_d    = (state_d == S_REQ) ? fetch_pc_d : mem_addr_q;
    instr_valid_d = (count_d != '0);

    // Head is registered; bypass the incoming word when it lands in the head slot.
    instr_d = instr_q;
    pc_d    = pc_q;
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        instr_d = mem_rdata;
        pc_d    = mem_addr_q;
      end else begin
        instr_d = data_q[rd_ptr_d];
        pc_d    = pcs_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= RESET_PC;
      mem_addr_q    <= RESET_PC;
      mem_req_q     <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      pc_q          <= '0;
`ifdef IFB_MISALIGN_CHECK_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      mem_addr_q    <= mem_addr_d;
      mem_req_q     <= mem_req_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
`ifdef IFB_MISALIGN_CHECK_EN
      fault_q       <= fault_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= mem_rdata;
      pcs_q[wr_ptr_q]  <= mem_addr_q;
    end
  end

endmodule

// File: doc/instr_fetch_buffer.md
# instr_fetch_buffer

Instruction fetch stage sitting directly upstream of the single-cycle core. Issues sequential word reads to instruction memory over a req/ack handshake, buffers returned words with their PCs in a small prefetch FIFO, and presents them to the core's `instruction` input with a valid/ready handshake. Handles branch/jump redirects by flushing the buffer and discarding any in-flight return.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, minimum 2.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; word aligned.
- `clk`  in  1  system clock; all state updates on rising edge.
- `nrst`  in  1  asynchronous active-low reset.
- `mem_req`  out  1  read request to instruction memory.
- `mem_addr`  out  32  word address of the request; stable while `mem_req`=1 and no ack.
- `mem_ack`  in  1  memory accepts and returns data this cycle.
- `mem_rdata`  in  32  read data; valid only in a cycle with `mem_ack`=1.
- `redirect`  in  1  one-cycle pulse from the core: flush and refetch.
- `redirect_pc`  in  32  new fetch address, sampled when `redirect`=1.
- `instr_valid`  out  1  head FIFO entry is valid.
- `instr_ready`  in  1  core consumes head entry this cycle.
- `instruction`  out  32  head instruction word.
- `pc`  out  32  address of the head instruction.
- `fetch_fault`  out  1  misaligned redirect trap (see Configuration).

## Operation
- FIFO holds {pc, instruction} pairs; `count` 0..DEPTH; read/write pointers wrap modulo DEPTH.
- Pop when `instr_valid & instr_ready`; push when a non-discarded `mem_ack` arrives.
- At most one request outstanding. `fetch_pc` is the next address to request; increments by 4 per accepted word, wraps 32'hFFFF_FFFC -> 0.
- States: IDLE (no request, waiting for space), REQ (`mem_req`=1, `mem_addr`=`fetch_pc`), DROP (`mem_req`=1 with stale address, return will be discarded), FAULT.
- IDLE -> REQ when space = (count - pop) < DEPTH.
- REQ, `mem_ack` and no redirect: push, `fetch_pc`+=4; stay REQ if (count + 1 - pop) < DEPTH, else IDLE.
- REQ, `redirect` without `mem_ack`: flush FIFO, latch `redirect_pc` as `fetch_pc`, -> DROP. Request is never withdrawn; `mem_addr` keeps old value.
- REQ, `redirect` with `mem_ack`: data discarded, flush, `fetch_pc`=`redirect_pc`, -> REQ.
- DROP, `mem_ack`: discard data, -> REQ. DROP, `redirect`: overwrite `fetch_pc`, flush again, stay DROP.
- IDLE, `redirect`: flush, load `fetch_pc`, -> REQ.
- Redirect beats pop: a pop in a redirect cycle is ignored (FIFO cleared regardless).
- Full FIFO with simultaneous pop and push: both occur, count unchanged.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=`RESET_PC`, `instr_valid`=0, `instruction`=0, `pc`=0, `fetch_fault`=0; state IDLE, count 0, `fetch_pc`=`RESET_PC`.
- First `mem_req` in the first cycle after `nrst` rises.
- Ack at edge N -> `instr_valid`=1 with that word from cycle N+1 (1-cycle latency, registered outputs).
- Back-to-back acks sustain one instruction per cycle; `mem_req` does not drop between sequential requests while space remains.
- Redirect at edge N -> `instr_valid`=0 in cycle N+1; new address on `mem_addr` in cycle N+1 unless in DROP.
- `nrst` assertion mid-transaction returns all state to reset values immediately; memory side must tolerate abandoned request.

## Configuration
- `IFB_MISALIGN_CHECK_EN` defined: redirect with `redirect_pc[1:0]`≠0 flushes, enters FAULT, asserts `fetch_fault` from next cycle, issues no requests; only an aligned redirect (or reset) exits FAULT to REQ and clears `fetch_fault`. Pending DROP ack still absorbed before FAULT stops requests.
- Not defined: `redirect_pc[1:0]` forced to 0; FAULT state absent; `fetch_fault` tied 0.

## Test plan
- Reset, memory acks every cycle with data 32'h3e800093, 32'h83000113, 32'h3e906193, `instr_ready`=1 -> core sees those words at pc 0, 4, 8 on consecutive cycles.
- `instr_ready`=0, acks always -> exactly DEPTH pushes, then `mem_req`=0; raise ready -> one pop per cycle, requests resume next cycle.
- Ack delayed 3 cycles on address 8, `redirect`=1 with `redirect_pc`=32'h100 in first wait cycle -> `mem_addr` stays 8 until ack, data discarded, next `mem_addr`=32'h100, first delivered pc 32'h100.
- Redirect coinciding with ack and with pop on full FIFO -> FIFO empty next cycle, no stale word delivered.
- Full FIFO, pop and ack same cycle -> count stays DEPTH, order preserved.
- With `IFB_MISALIGN_CHECK_EN`, redirect to 32'h102 -> `fetch_fault`=1, `mem_req`=0; redirect to 32'h104 -> fault clears, fetch from 32'h104.
